// File: rtl/word_assembler.sv
// Packs SLICES narrow slices into one registered word. The word is valid one cycle after the load that fills the last slice.
// While a word waits for the consumer, loadReady drops and incoming loads are dropped; a handoff edge can also accept the first slice of the next word.
module word_assembler #(
  parameter int SLICE_W = 4,
  parameter int SLICES  = 2,
  parameter int SEL_W   = $clog2(SLICES)
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [SLICE_W-1:0]         dataIN,
  input  logic                       loadEn,
  input  logic [SEL_W-1:0]           loadSel,
  input  logic                       autoMode,
  input  logic                       clear,
  output logic                       loadReady,
  output logic [SLICE_W*SLICES-1:0]  wordOUT,
  output logic                       wordValid,
  input  logic                       wordReady,
  output logic [SLICES-1:0]          fillMask,
  output logic [SEL_W-1:0]           ptr
);

  localparam int WORD_W = SLICE_W * SLICES;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(SLICES - 1);

  logic              accept;
  logic              handoff;
  logic              write;
  logic              sel_ok;
  logic [SEL_W-1:0]  idx;
  logic [SEL_W-1:0]  ptr_base;
  logic [SLICES-1:0] mask_base;

  logic [WORD_W-1:0] word_n;
  logic [SLICES-1:0] mask_n;
  logic [SEL_W-1:0]  ptr_n;
  logic              valid_n;

  assign loadReady = !wordValid | wordReady;
  assign handoff   = wordValid & wordReady;
  assign accept    = loadEn & loadReady & !clear;
  assign sel_ok    = int'(loadSel) < SLICES;

  // A handoff edge starts the next word from an empty mask and slice 0.
  assign ptr_base  = handoff ? '0 : ptr;
  assign mask_base = handoff ? '0 : fillMask;
  assign idx       = autoMode ? ptr_base : loadSel;
  assign write     = accept & (autoMode | sel_ok);

  always_comb begin
    word_n  = wordOUT;
    mask_n  = mask_base;
    ptr_n   = ptr_base;
    valid_n = 1'b0;
    if (write) begin
      for (int i = 0; i < SLICES; i++) begin
        if (idx == SEL_W'(i)) begin
          word_n[i*SLICE_W +: SLICE_W] = dataIN;
          mask_n[i]                    = 1'b1;
        end
      end
      if (autoMode) begin
        ptr_n = (ptr_base == LAST_SEL) ? '0 : ptr_base + SEL_W'(1);
      end
    end
    valid_n = &mask_n;
    if (clear) begin
      word_n  = '0;
      mask_n  = '0;
      ptr_n   = '0;
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wordOUT   <= '0;
      fillMask  <= '0;
      ptr       <= '0;
      wordValid <= 1'b0;
    end else begin
      wordOUT   <= word_n;
      fillMask  <= mask_n;
      ptr       <= ptr_n;
      wordValid <= valid_n;
    end
  end

endmodule

// File: doc/word_assembler.md
Name: word_assembler

Overview:
- Packs narrow input slices into one wide output word: SLICES slices of SLICE_W bits each.
- Slice 0 occupies the LSBs of the word.
- Two load modes:
  - Addressed: the caller picks the slice.
  - Sequential: an internal pointer picks the slice.
- The completed word is presented with a valid/ready handshake to the downstream consumer.
- Sits between the narrow input path (switches/bus) and the 8-bit datapath registers; the defaults reproduce a two-nibble, 8-bit packer.

Parameters:
SLICE_W, 4, bits per input slice (>=1)
SLICES, 2, slices per word (>=2; need not be a power of two)
SEL_W, $clog2(SLICES), width of slice select and pointer (derived; do not override)

Ports:
clk  in  1  system clock, all state on rising edge
rstN  in  1  asynchronous active-low reset
dataIN  in  SLICE_W  slice data to load
loadEn  in  1  load request for this cycle
loadSel  in  SEL_W  target slice in addressed mode
autoMode  in  1  0 = addressed load, 1 = sequential load; sampled per load
clear  in  1  synchronous abort of the current word
loadReady  out  1  load accepted this cycle when loadEn=1
wordOUT  out  SLICE_W*SLICES  assembled word, registered
wordValid  out  1  wordOUT complete and held
wordReady  in  1  consumer accepts word when wordValid=1
fillMask  out  SLICES  bit i set once slice i has been loaded in the current word
ptr  out  SEL_W  sequential-mode next slice index (debug)

Behaviour:
- Reset (rstN=0, asynchronous): wordOUT=0, wordValid=0, fillMask=0, ptr=0, loadReady=1. The block stays in this state until rstN deasserts. Deassertion is taken synchronously by the integrator.
- loadReady is combinational: !wordValid | wordReady.
- A load is accepted when loadEn & loadReady & !clear.
  - While wordValid=1 and wordReady=0, loads are dropped and all state holds, including wordOUT.
- Accepted load, addressed mode (autoMode=0):
  - The slice at loadSel is written with dataIN, and fillMask[loadSel] is set.
  - ptr is unchanged.
  - If loadSel >= SLICES, the load is ignored with no state change; loadReady is still reported.
- Accepted load, sequential mode (autoMode=1):
  - The slice at ptr is written and fillMask[ptr] is set.
  - ptr advances by 1, wrapping from SLICES-1 to 0.
- Reloading an already-filled slice overwrites it. The mask bit stays set.
- Completion:
  - wordValid rises on the clock edge after the load that makes fillMask all-ones.
  - Latency is 1 cycle from the final accepted load to wordValid=1.
  - wordOUT is stable while wordValid=1.
- Handoff: on an edge with wordValid & wordReady:
  - wordValid goes to 0, fillMask goes to 0, ptr goes to 0.
  - wordOUT keeps its value until overwritten slice by slice.
- Simultaneous handoff and accepted load, same edge:
  - The new word starts with only the loaded slice marked in fillMask.
  - Sequential mode loads slice 0 and sets ptr=1. Addressed mode loads loadSel.
  - No load is lost and no bubble is inserted.
- clear has highest priority, synchronous:
  - fillMask=0, ptr=0, wordValid=0, wordOUT=0.
  - Any loadEn or wordReady in the same cycle is ignored.
- Mixing modes within one word is legal.
  - Addressed loads do not move ptr.
  - Completion depends only on fillMask.
- Reset mid-word: the partial word is discarded and all outputs return to their reset values immediately.
- No combinational path from dataIN to wordOUT.

Test Plan:
1. Defaults, sequential mode: loads 0x5, then 0xA; wordReady=0 → cycle after 2nd load wordValid=1, wordOUT=0xA5, fillMask=2'b11; loadReady=0, and a 3rd load of 0xF is dropped with wordOUT still 0xA5.
2. Addressed mode with SLICE_W=4, SLICES=3: load sel2=0xC, then sel0=0x3, then sel2=0xD, then sel1=0x7 → wordValid=1 only after the 4th load; wordOUT=0xD73. Then loadSel=3 → ignored.
3. Back-to-back: wordValid=1 with wordReady=1, and a sequential load of 0x9 on the same edge → wordValid=0, fillMask=2'b01, ptr=1, wordOUT[3:0]=0x9. Next load of 0x4 → wordValid=1, wordOUT=0x49.
4. Clear precedence: after one sequential load 0x6, assert clear together with loadEn (0xE) → fillMask=0, ptr=0, wordOUT=0, wordValid=0. Next two loads complete normally.
5. Async reset mid-word: after one load, pull rstN low between clock edges → outputs reach reset values before the next edge; loadReady=1.
6. Mixed mode: sequential 0x1 (ptr goes to 1), then addressed sel0=0x2, then sequential 0x3 → wordOUT=0x32, wordValid=1.
